// File: rtl/afpm_pkg.sv
// rtl/afpm_pkg.sv - shared widths, tx state encoding and helpers for the AFPM result serializer
package afpm_pkg;

    localparam int BYTE_W = 8;
    localparam int DATA_W = 2 * BYTE_W;

    // TX_CHK stays in the encoding so both builds share one state layout.
    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_LO   = 3'd1,
        TX_HI   = 3'd2,
        TX_CHK  = 3'd3,
        TX_GAP  = 3'd4
    } tx_state_e;

    localparam logic [BYTE_W-1:0] IDLE_VALUE_DEFAULT = 8'h00;

    function automatic logic [BYTE_W-1:0] beat_xor(input logic [DATA_W-1:0] word);
        return word[BYTE_W-1:0] ^ word[DATA_W-1:BYTE_W];
    endfunction

endpackage

// File: rtl/afpm_result_serializer_if.sv
// rtl/afpm_result_serializer_if.sv - result handshake and serial beat bundle
interface afpm_result_serializer_if;
    import afpm_pkg::*;

    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic [BYTE_W-1:0] out_byte;
    logic              out_strobe;
    logic              out_first;
    logic              out_last;
    logic              busy;

    // master: the core/environment side; slave: the serializer.
    modport master (
        output res_valid, res_data,
        input  res_ready, out_byte, out_strobe, out_first, out_last, busy
    );

    modport slave (
        input  res_valid, res_data,
        output res_ready, out_byte, out_strobe, out_first, out_last, busy
    );

endinterface

// File: rtl/afpm_tx_buffer.sv
// rtl/afpm_tx_buffer.sv - one-entry holding register between the core handshake and the beat FSM
module afpm_tx_buffer
    import afpm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (ena) begin
            // load and clear are mutually exclusive: load needs the buffer empty.
            if (clear) begin
                full_d = 1'b0;
            end
            if (load) begin
                data_d = din;
                full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign dout = data_q;
    assign full = full_q;

endmodule

// File: rtl/afpm_result_serializer.sv
// rtl/afpm_result_serializer.sv - sends 16-bit AFPM results as low/high byte beats on uo_out
// Optional XOR checksum beat enabled by defining AFPM_TX_CHECKSUM_EN.
module afpm_result_serializer
    import afpm_pkg::*;
#(
    parameter int                GAP_CYCLES = 0,
    parameter logic [BYTE_W-1:0] IDLE_VALUE = IDLE_VALUE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ena,
    afpm_result_serializer_if.slave   bus
);

    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
    localparam logic [3:0] GAP_INIT = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        gap_q, gap_d;
    logic [BYTE_W-1:0] out_byte_q, out_byte_d;
    logic              out_strobe_q, out_strobe_d;
    logic              out_first_q, out_first_d;
    logic              out_last_q, out_last_d;
    logic              busy_q, busy_d;

    logic              buf_full;
    logic              buf_load;
    logic              buf_clear;
    logic [DATA_W-1:0] buf_data;
    logic              res_ready_w;
    logic              end_frame;
    logic              start_frame;

    assign res_ready_w = rst_n & ena & ~buf_full;
    assign buf_load    = bus.res_valid & res_ready_w;

    afpm_tx_buffer u_buffer (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .load  (buf_load),
        .clear (buf_clear),
        .din   (bus.res_data),
        .dout  (buf_data),
        .full  (buf_full)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        gap_d        = gap_q;
        out_byte_d   = out_byte_q;
        out_strobe_d = out_strobe_q;
        out_first_d  = out_first_q;
        out_last_d   = out_last_q;
        buf_clear    = 1'b0;
        end_frame    = 1'b0;
        start_frame  = 1'b0;

        if (ena) begin
            out_byte_d   = IDLE_VALUE;
            out_strobe_d = 1'b0;
            out_first_d  = 1'b0;
            out_last_d   = 1'b0;

            case (state_q)
                TX_IDLE: begin
                    start_frame = buf_full;
                end
                TX_LO: begin
                    state_d      = TX_HI;
                    out_byte_d   = shift_q[DATA_W-1:BYTE_W];
                    out_strobe_d = 1'b1;
`ifdef AFPM_TX_CHECKSUM_EN
                    out_last_d   = 1'b0;
`else
                    out_last_d   = 1'b1;
`endif
                end
                TX_HI: begin
`ifdef AFPM_TX_CHECKSUM_EN
                    state_d      = TX_CHK;
                    out_byte_d   = beat_xor(shift_q);
                    out_strobe_d = 1'b1;
                    out_last_d   = 1'b1;
`else
                    end_frame    = 1'b1;
`endif
                end
                TX_CHK: begin
`ifdef AFPM_TX_CHECKSUM_EN
                    end_frame = 1'b1;
`else
                    state_d   = TX_IDLE;
`endif
                end
                TX_GAP: begin
                    if (gap_q == 4'd0) begin
                        start_frame = buf_full;
                        if (!buf_full) begin
                            state_d = TX_IDLE;
                        end
                    end else begin
                        gap_d = gap_q - 4'd1;
                    end
                end
                default: begin
                    state_d = TX_IDLE;
                end
            endcase

            // With no gap configured the next buffered word follows the last beat directly.
            if (end_frame) begin
                if (HAS_GAP) begin
                    state_d = TX_GAP;
                    gap_d   = GAP_INIT;
                end else if (buf_full) begin
                    start_frame = 1'b1;
                end else begin
                    state_d = TX_IDLE;
                end
            end

            if (start_frame) begin
                state_d      = TX_LO;
                shift_d      = buf_data;
                buf_clear    = 1'b1;
                out_byte_d   = buf_data[BYTE_W-1:0];
                out_strobe_d = 1'b1;
                out_first_d  = 1'b1;
            end
        end

        busy_d = ((buf_full & ~buf_clear) | buf_load) | (state_d != TX_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= TX_IDLE;
            shift_q      <= '0;
            gap_q        <= 4'd0;
            out_byte_q   <= IDLE_VALUE;
            out_strobe_q <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            gap_q        <= gap_d;
            out_byte_q   <= out_byte_d;
            out_strobe_q <= out_strobe_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.res_ready  = res_ready_w;
    assign bus.out_byte   = out_byte_q;
    assign bus.out_strobe = out_strobe_q;
    assign bus.out_first  = out_first_q;
    assign bus.out_last   = out_last_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_afpm_result_serializer.sv
// tb/tb_afpm_result_serializer.sv - directed self-checking bench for afpm_result_serializer
module tb_afpm_result_serializer;
    import afpm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    afpm_result_serializer_if bus0 ();
    afpm_result_serializer_if bus2 ();

    afpm_result_serializer #(.GAP_CYCLES(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus0)
    );

    afpm_result_serializer #(.GAP_CYCLES(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus2)
    );

    // Expected-vector nibble: {res_ready, out_first, out_last, out_strobe}, then out_byte.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena = 1'b1;
        bus0.res_valid = 1'b0;
        bus0.res_data = '0;
        bus2.res_valid = 1'b0;
        bus2.res_data = '0;
        tick();
        tick();
        tests_run++;
        if ({bus0.res_ready, bus0.out_first, bus0.out_last, bus0.out_strobe, bus0.out_byte} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h want 000",
                     {bus0.res_ready, bus0.out_first, bus0.out_last, bus0.out_strobe, bus0.out_byte});
        end
        tests_run++;
        if (bus0.busy !== 1'b0 || bus2.busy !== 1'b0 || bus2.out_strobe !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_busy: got %b%b%b want 000", bus0.busy, bus2.busy, bus2.out_strobe);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus0.res_ready !== 1'b1 || bus2.res_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b%b want 11", bus0.res_ready, bus2.res_ready);
        end
    endtask

    task automatic test_single();
        logic [11:0] exp_q[$];
        logic [11:0] obs;
`ifdef AFPM_TX_CHECKSUM_EN
        exp_q = '{12'h000, 12'hDDF, 12'h944, 12'hB9B, 12'h800};
`else
        exp_q = '{12'h000, 12'hDDF, 12'hB44, 12'h800};
`endif
        bus0.res_data = 16'h44DF;
        bus0.res_valid = 1'b1;
        tick();
        bus0.res_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) tick();
            obs = {bus0.res_ready, bus0.out_first, bus0.out_last, bus0.out_strobe, bus0.out_byte};
            tests_run++;
            if (obs !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL single_beat%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
        tests_run++;
        if (bus0.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_busy_clear: got %b want 0", bus0.busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_q[$];
        logic [11:0] obs;
`ifdef AFPM_TX_CHECKSUM_EN
        exp_q = '{12'h000, 12'hD34, 12'h112, 12'h326, 12'hDCD, 12'h9AB, 12'hB66, 12'h800};
`else
        exp_q = '{12'h000, 12'hD34, 12'h312, 12'hDCD, 12'hBAB, 12'h800};
`endif
        bus0.res_data = 16'h1234;
        bus0.res_valid = 1'b1;
        tick();
        bus0.res_data = 16'hABCD;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) tick();
            if (i == 2) bus0.res_valid = 1'b0;
            obs = {bus0.res_ready, bus0.out_first, bus0.out_last, bus0.out_strobe, bus0.out_byte};
            tests_run++;
            if (obs !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL b2b_beat%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
    endtask

    task automatic test_gap();
        logic [11:0] exp_q[$];
        logic [11:0] obs;
`ifdef AFPM_TX_CHECKSUM_EN
        exp_q = '{12'h000, 12'hD34, 12'h112, 12'h326, 12'h000, 12'h000,
                  12'hDCD, 12'h9AB, 12'hB66, 12'h800, 12'h800, 12'h800};
`else
        exp_q = '{12'h000, 12'hD34, 12'h312, 12'h000, 12'h000,
                  12'hDCD, 12'hBAB, 12'h800, 12'h800, 12'h800};
`endif
        bus2.res_data = 16'h1234;
        bus2.res_valid = 1'b1;
        tick();
        bus2.res_data = 16'hABCD;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) tick();
            if (i == 2) bus2.res_valid = 1'b0;
            obs = {bus2.res_ready, bus2.out_first, bus2.out_last, bus2.out_strobe, bus2.out_byte};
            tests_run++;
            if (obs !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL gap_beat%0d: got %h want %h", i, obs, exp_q[i]);
            end
        end
        tests_run++;
        if (bus2.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_busy_clear: got %b want 0", bus2.busy);
        end
    endtask

    task automatic test_ena_hold();
        logic [11:0] obs;
        bus0.res_data = 16'h44DF;
        bus0.res_valid = 1'b1;
        tick();
        bus0.res_valid = 1'b0;
        tick();
        ena = 1'b0;
        #1;
        tests_run++;
        if (bus0.res_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL ena_ready_low: got %b want 0", bus0.res_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {bus0.res_ready, bus0.out_first, bus0.out_last, bus0.out_strobe, bus0.out_byte};
            tests_run++;
            if (obs !== 12'h5DF) begin
                tests_failed++;
                $display("FAIL ena_hold%0d: got %h want 5df", i, obs);
            end
        end
        ena = 1'b1;
        tick();
        obs = {bus0.res_ready, bus0.out_first, bus0.out_last, bus0.out_strobe, bus0.out_byte};
        tests_run++;
`ifdef AFPM_TX_CHECKSUM_EN
        if (obs !== 12'h944) begin
            tests_failed++;
            $display("FAIL ena_resume: got %h want 944", obs);
        end
`else
        if (obs !== 12'hB44) begin
            tests_failed++;
            $display("FAIL ena_resume: got %h want b44", obs);
        end
`endif
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] obs;
        bus0.res_data = 16'h44DF;
        bus0.res_valid = 1'b1;
        tick();
        bus0.res_data = 16'h1234;
        tick();
        tests_run++;
        if (bus0.out_byte !== 8'hDF || bus0.out_strobe !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_lo_beat: got %h/%b want df/1", bus0.out_byte, bus0.out_strobe);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus0.res_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_ready_in_reset: got %b want 0", bus0.res_ready);
        end
        tick();
        obs = {bus0.res_ready, bus0.out_first, bus0.out_last, bus0.out_strobe, bus0.out_byte};
        tests_run++;
        if (obs !== 12'h000 || bus0.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_outputs: got %h busy %b want 000 busy 0", obs, bus0.busy);
        end
        bus0.res_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (bus0.res_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL rstmid_ready_release: got %b want 1", bus0.res_ready);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            obs = {bus0.res_ready, bus0.out_first, bus0.out_last, bus0.out_strobe, bus0.out_byte};
            tests_run++;
            if (obs !== 12'h800) begin
                tests_failed++;
                $display("FAIL rstmid_quiet%0d: got %h want 800", i, obs);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_ena_hold();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
